// File: rtl/scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : scan_decoder
//  Description : Registered one-hot address decoder with direct-hold and
//                auto-scan modes.
//                A request (in_valid & in_ready) loads an index. In HOLD the
//                matching result bit stays asserted until a new request
//                arrives. In SCAN the index advances every DWELL cycles and
//                wraps from OUT_N-1 back to 0.
//
//  Parameters  : WIDTH - address width, OUT_N = 2**WIDTH outputs (1..6)
//                DWELL - cycles per index in scan mode (1..255)
//
//  Ports       : clk       in   sole clock, rising edge
//                reset     in   synchronous active-low reset
//                en        in   block enable; low forces outputs off
//                in_valid  in   request valid
//                in_ready  out  request accepted this cycle (combinational)
//                address   in   target index / scan start index
//                mode      in   0 = direct hold, 1 = auto-scan
//                stop      in   freeze scan at the current index
//                result    out  [0:OUT_N-1] one-hot select, result[0] = index 0
//                cur_addr  out  index currently decoded
//                wrap      out  one-cycle pulse when scan wraps OUT_N-1 -> 0
//                busy      out  high in HOLD or SCAN
//
//  Build macro : SCAN_DECODER_SCAN_EN - compiles in the SCAN state, dwell
//                counter, stop and wrap. When undefined, every request goes
//                to HOLD, mode and stop are ignored and wrap is tied low.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_decoder #(
    parameter int WIDTH = 2,
    parameter int DWELL = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         address,
    input  logic                     mode,
    input  logic                     stop,
    output logic [0:(1<<WIDTH)-1]    result,
    output logic [WIDTH-1:0]         cur_addr,
    output logic                     wrap,
    output logic                     busy
);

    localparam int c_OUT_N = 1 << WIDTH;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HOLD = 2'd1;
`ifdef SCAN_DECODER_SCAN_EN
    localparam logic [1:0] c_ST_SCAN = 2'd2;

    // Dwell counter is sized for the largest legal DWELL (255).
    localparam logic [7:0]       c_DWELL_LAST = 8'(DWELL - 1);
    localparam logic [WIDTH-1:0] c_ONE        = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_LAST_IDX   = WIDTH'(c_OUT_N - 1);
`endif

    logic [1:0]         r_state;
    logic [0:c_OUT_N-1] r_result;
    logic [WIDTH-1:0]   r_cur_addr;
    logic               r_busy;
    logic               w_accept;
    logic [0:c_OUT_N-1] w_hot_addr;

`ifdef SCAN_DECODER_SCAN_EN
    logic               r_wrap;
    logic [7:0]         r_dwell;
    logic [WIDTH-1:0]   w_next_addr;
    logic [0:c_OUT_N-1] w_hot_next;

    // Index arithmetic relies on natural WIDTH-bit wrap for mod OUT_N.
    assign w_next_addr = r_cur_addr + c_ONE;
`else
    // Scan controls have no effect in a hold-only build.
    logic w_unused_scan_ctrl;
    assign w_unused_scan_ctrl = mode ^ stop;
`endif

    // ------------------------------------------------------------------
    // One-hot decoders: index i lands on result[i] (MSB side of vector).
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < c_OUT_N; g++) begin : g_onehot
            localparam logic [WIDTH-1:0] c_IDX = WIDTH'(g);
            assign w_hot_addr[g] = (address == c_IDX);
`ifdef SCAN_DECODER_SCAN_EN
            assign w_hot_next[g] = (w_next_addr == c_IDX);
`endif
        end
    endgenerate

    // Requests are only taken while enabled and not scanning.
`ifdef SCAN_DECODER_SCAN_EN
    assign in_ready = en & (r_state != c_ST_SCAN);
`else
    assign in_ready = en;
`endif

    assign w_accept = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Control FSM. Priority: reset, en=0, stop, dwell advance.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_ST_IDLE;
            r_result   <= '0;
            r_cur_addr <= '0;
            r_busy     <= 1'b0;
`ifdef SCAN_DECODER_SCAN_EN
            r_wrap     <= 1'b0;
            r_dwell    <= '0;
`endif
        end else if (!en) begin
            // Disable drops to IDLE but keeps cur_addr for observation.
            r_state  <= c_ST_IDLE;
            r_result <= '0;
            r_busy   <= 1'b0;
`ifdef SCAN_DECODER_SCAN_EN
            r_wrap   <= 1'b0;
            r_dwell  <= '0;
`endif
        end else begin
`ifdef SCAN_DECODER_SCAN_EN
            r_wrap <= 1'b0;
`endif
            case (r_state)
                c_ST_IDLE, c_ST_HOLD: begin
                    if (w_accept) begin
                        r_cur_addr <= address;
                        r_result   <= w_hot_addr;
                        r_busy     <= 1'b1;
`ifdef SCAN_DECODER_SCAN_EN
                        r_dwell    <= '0;
                        r_state    <= mode ? c_ST_SCAN : c_ST_HOLD;
`else
                        r_state    <= c_ST_HOLD;
`endif
                    end
                end
`ifdef SCAN_DECODER_SCAN_EN
                c_ST_SCAN: begin
                    if (stop) begin
                        // Freeze without advancing, even on the last dwell cycle.
                        r_state <= c_ST_HOLD;
                        r_dwell <= '0;
                    end else if (r_dwell == c_DWELL_LAST) begin
                        r_dwell    <= '0;
                        r_cur_addr <= w_next_addr;
                        r_result   <= w_hot_next;
                        r_wrap     <= (r_cur_addr == c_LAST_IDX);
                    end else begin
                        r_dwell <= r_dwell + 8'd1;
                    end
                end
`endif
                default: begin
                    r_state  <= c_ST_IDLE;
                    r_result <= '0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign result   = r_result;
    assign cur_addr = r_cur_addr;
    assign busy     = r_busy;
`ifdef SCAN_DECODER_SCAN_EN
    assign wrap     = r_wrap;
`else
    assign wrap     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_decoder
//  Description : Scoreboard bench for scan_decoder (WIDTH=2, DWELL=2).
//                Each directed vector pushes its hand-computed expected
//                outputs; a monitor pops and compares one cycle later.
//                Scan-specific vectors follow SCAN_DECODER_SCAN_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] address;
    logic       mode;
    logic       stop;
    logic [0:3] result;
    logic [1:0] cur_addr;
    logic       wrap;
    logic       busy;

    always #5 clk = ~clk;

    scan_decoder #(.WIDTH(2), .DWELL(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .address  (address),
        .mode     (mode),
        .stop     (stop),
        .result   (result),
        .cur_addr (cur_addr),
        .wrap     (wrap),
        .busy     (busy)
    );

    typedef struct {
        logic [0:3] res;
        logic [1:0] cur;
        logic       wrp;
        logic       bsy;
        logic       rdy;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input string fld, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s actual=%b expected=%b", nm, fld, act, exp);
        end
    endtask

    // Monitor: compares the outputs produced by the edge that follows each push.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.name, "result",   result,               e.res);
            chk(e.name, "cur_addr", {2'b00, cur_addr},    {2'b00, e.cur});
            chk(e.name, "wrap",     {3'b000, wrap},       {3'b000, e.wrp});
            chk(e.name, "busy",     {3'b000, busy},       {3'b000, e.bsy});
            chk(e.name, "in_ready", {3'b000, in_ready},   {3'b000, e.rdy});
            chk(e.name, "onehot",   {3'b000, ($countones(result) <= 1)}, 4'b0001);
        end
    end

    // One vector: inputs applied before the next rising edge, outputs expected after it.
    task automatic vec(input logic rn, input logic e, input logic v, input logic [1:0] a,
                       input logic m, input logic s, input logic [3:0] xres,
                       input logic [1:0] xcur, input logic xw, input logic xb,
                       input logic xr, input string nm);
        exp_t x;
        @(negedge clk);
        reset    = rn;
        en       = e;
        in_valid = v;
        address  = a;
        mode     = m;
        stop     = s;
        x.res  = xres;
        x.cur  = xcur;
        x.wrp  = xw;
        x.bsy  = xb;
        x.rdy  = xr;
        x.name = nm;
        q.push_back(x);
    endtask

    initial begin
        int guard;
        reset = 1'b0; en = 1'b1; in_valid = 1'b0; address = 2'd0; mode = 1'b0; stop = 1'b0;

        //   rst en  vld addr mode stop  result   cur  wrp bsy rdy
        vec(1'b0,1'b1,1'b0,2'd0,1'b0,1'b0, 4'b0000,2'd0,1'b0,1'b0,1'b1,"reset1");
        vec(1'b0,1'b1,1'b0,2'd0,1'b0,1'b0, 4'b0000,2'd0,1'b0,1'b0,1'b1,"reset2");
        vec(1'b1,1'b1,1'b0,2'd0,1'b0,1'b0, 4'b0000,2'd0,1'b0,1'b0,1'b1,"idle_after_reset");
        vec(1'b1,1'b1,1'b1,2'd2,1'b0,1'b0, 4'b0010,2'd2,1'b0,1'b1,1'b1,"hold_a2");
        vec(1'b1,1'b1,1'b1,2'd3,1'b0,1'b0, 4'b0001,2'd3,1'b0,1'b1,1'b1,"hold_b2b_a3");
        vec(1'b1,1'b1,1'b0,2'd0,1'b0,1'b0, 4'b0001,2'd3,1'b0,1'b1,1'b1,"hold_keep1");
        vec(1'b1,1'b1,1'b0,2'd0,1'b0,1'b0, 4'b0001,2'd3,1'b0,1'b1,1'b1,"hold_keep2");
        vec(1'b1,1'b0,1'b1,2'd1,1'b0,1'b0, 4'b0000,2'd3,1'b0,1'b0,1'b0,"disable_hold");
        vec(1'b1,1'b1,1'b0,2'd0,1'b0,1'b0, 4'b0000,2'd3,1'b0,1'b0,1'b1,"reenable_idle");

`ifdef SCAN_DECODER_SCAN_EN
        // Scan from 3, DWELL=2: 0001,0001,1000(wrap),1000,0100,0100
        vec(1'b1,1'b1,1'b1,2'd3,1'b1,1'b0, 4'b0001,2'd3,1'b0,1'b1,1'b0,"scan_enter3");
        vec(1'b1,1'b1,1'b1,2'd0,1'b0,1'b0, 4'b0001,2'd3,1'b0,1'b1,1'b0,"scan_ignore_req");
        vec(1'b1,1'b1,1'b0,2'd0,1'b0,1'b0, 4'b1000,2'd0,1'b1,1'b1,1'b0,"scan_wrap");
        vec(1'b1,1'b1,1'b0,2'd0,1'b0,1'b0, 4'b1000,2'd0,1'b0,1'b1,1'b0,"scan_idx0_d2");
        vec(1'b1,1'b1,1'b0,2'd0,1'b0,1'b0, 4'b0100,2'd1,1'b0,1'b1,1'b0,"scan_idx1_d1");
        vec(1'b1,1'b1,1'b0,2'd0,1'b0,1'b0, 4'b0100,2'd1,1'b0,1'b1,1'b0,"scan_idx1_d2");
        vec(1'b1,1'b1,1'b0,2'd0,1'b0,1'b1, 4'b0100,2'd1,1'b0,1'b1,1'b1,"stop_no_advance");
        vec(1'b1,1'b1,1'b0,2'd0,1'b0,1'b0, 4'b0100,2'd1,1'b0,1'b1,1'b1,"stop_hold");
        // Back into scan from HOLD, then en=0 together with stop.
        vec(1'b1,1'b1,1'b1,2'd1,1'b1,1'b0, 4'b0100,2'd1,1'b0,1'b1,1'b0,"scan_from_hold");
        vec(1'b1,1'b1,1'b0,2'd0,1'b0,1'b0, 4'b0100,2'd1,1'b0,1'b1,1'b0,"scan_idx1_dwell");
        vec(1'b1,1'b1,1'b0,2'd0,1'b0,1'b0, 4'b0010,2'd2,1'b0,1'b1,1'b0,"scan_idx2");
        vec(1'b1,1'b0,1'b0,2'd0,1'b0,1'b1, 4'b0000,2'd2,1'b0,1'b0,1'b0,"en_low_beats_stop");
        vec(1'b1,1'b1,1'b0,2'd0,1'b0,1'b0, 4'b0000,2'd2,1'b0,1'b0,1'b1,"idle_keep_addr");
        // Reset exactly where the scan would wrap: no pulse.
        vec(1'b1,1'b1,1'b1,2'd3,1'b1,1'b0, 4'b0001,2'd3,1'b0,1'b1,1'b0,"scan_enter3b");
        vec(1'b1,1'b1,1'b0,2'd0,1'b0,1'b0, 4'b0001,2'd3,1'b0,1'b1,1'b0,"scan_idx3_d2");
        vec(1'b0,1'b1,1'b0,2'd0,1'b0,1'b0, 4'b0000,2'd0,1'b0,1'b0,1'b1,"reset_midscan");
        vec(1'b1,1'b1,1'b0,2'd0,1'b0,1'b0, 4'b0000,2'd0,1'b0,1'b0,1'b1,"ready_after_reset");
        // Entry at address 0 is not a wrap.
        vec(1'b1,1'b1,1'b1,2'd0,1'b1,1'b0, 4'b1000,2'd0,1'b0,1'b1,1'b0,"scan_enter0");
        vec(1'b1,1'b1,1'b0,2'd0,1'b0,1'b0, 4'b1000,2'd0,1'b0,1'b1,1'b0,"scan_idx0_dwell");
        vec(1'b1,1'b1,1'b0,2'd0,1'b0,1'b0, 4'b0100,2'd1,1'b0,1'b1,1'b0,"scan_adv1");
        vec(1'b1,1'b0,1'b0,2'd0,1'b0,1'b0, 4'b0000,2'd1,1'b0,1'b0,1'b0,"disable_scan");
`else
        // Hold-only build: mode=1 still holds, stop is ignored, wrap stays low.
        vec(1'b1,1'b1,1'b1,2'd1,1'b1,1'b0, 4'b0100,2'd1,1'b0,1'b1,1'b1,"mode1_holds");
        for (int i = 0; i < 10; i++)
            vec(1'b1,1'b1,1'b0,2'd0,1'b1,i[0], 4'b0100,2'd1,1'b0,1'b1,1'b1,"hold_10cyc");
        vec(1'b1,1'b1,1'b1,2'd0,1'b1,1'b1, 4'b1000,2'd0,1'b0,1'b1,1'b1,"mode1_stop_a0");
        vec(1'b0,1'b1,1'b0,2'd0,1'b0,1'b0, 4'b0000,2'd0,1'b0,1'b0,1'b1,"reset_midhold");
        vec(1'b1,1'b1,1'b0,2'd0,1'b0,1'b0, 4'b0000,2'd0,1'b0,1'b0,1'b1,"ready_after_reset");
`endif

        // Drain the scoreboard within a bounded number of cycles.
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain actual=%0d pending expected=0 pending", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
